// File: rtl/flip_alpha_gen_pkg.sv
// Shared types, per-code field constants and GF helpers for the Chase flip alpha generator.
package flip_alpha_gen_pkg;

    localparam int unsigned FIELD_W = 10;
    localparam int unsigned POLY_W  = FIELD_W + 1;

    // Field select encoding carried on i_code
    localparam logic [1:0] CODE_GF6  = 2'b00;
    localparam logic [1:0] CODE_GF8  = 2'b01;
    localparam logic [1:0] CODE_GF10 = 2'b10;

    // Primitive polynomials including the x^m term
    localparam logic [POLY_W-1:0] POLY_GF6  = 11'h043;
    localparam logic [POLY_W-1:0] POLY_GF8  = 11'h11D;
    localparam logic [POLY_W-1:0] POLY_GF10 = 11'h409;

    // Field widths m
    localparam int unsigned M_GF6  = 6;
    localparam int unsigned M_GF8  = 8;
    localparam int unsigned M_GF10 = 10;

    // Index of the last bit in a frame (n - 1)
    localparam logic [FIELD_W-1:0] NLAST_GF6  = 10'd62;
    localparam logic [FIELD_W-1:0] NLAST_GF8  = 10'd254;
    localparam logic [FIELD_W-1:0] NLAST_GF10 = 10'd1022;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // CALC sequence: square, then odd powers, first for a1 then for a2
    typedef enum logic [2:0] {
        STEP_SQ_1 = 3'd0,
        STEP_P3_1 = 3'd1,
        STEP_P5_1 = 3'd2,
        STEP_P7_1 = 3'd3,
        STEP_SQ_2 = 3'd4,
        STEP_P3_2 = 3'd5,
        STEP_P5_2 = 3'd6,
        STEP_P7_2 = 3'd7
    } step_e;

    // Only the widest field needs alpha^5 and alpha^7; the unused code 11 behaves as GF(2^10)
    function automatic logic code_is_long(input logic [1:0] code);
        logic long_code;
        case (code)
            CODE_GF6:  long_code = 1'b0;
            CODE_GF8:  long_code = 1'b0;
            CODE_GF10: long_code = 1'b1;
            default:   long_code = 1'b1;
        endcase
        return long_code;
    endfunction

    function automatic logic [FIELD_W-1:0] code_nlast(input logic [1:0] code);
        logic [FIELD_W-1:0] nlast;
        case (code)
            CODE_GF6:  nlast = NLAST_GF6;
            CODE_GF8:  nlast = NLAST_GF8;
            CODE_GF10: nlast = NLAST_GF10;
            default:   nlast = NLAST_GF10;
        endcase
        return nlast;
    endfunction

    // Multiply by alpha: shift left and fold the x^m term back with the primitive polynomial
    function automatic logic [FIELD_W-1:0] gf_xtime(input logic [FIELD_W-1:0] x,
                                                    input logic [1:0]         code);
        logic [POLY_W-1:0] sh;
        sh = {x, 1'b0};
        case (code)
            CODE_GF6:  if (sh[M_GF6])  sh = sh ^ POLY_GF6;
            CODE_GF8:  if (sh[M_GF8])  sh = sh ^ POLY_GF8;
            CODE_GF10: if (sh[M_GF10]) sh = sh ^ POLY_GF10;
            default:   if (sh[M_GF10]) sh = sh ^ POLY_GF10;
        endcase
        return sh[FIELD_W-1:0];
    endfunction

    // CALC step sequencing; short codes skip the alpha^5/alpha^7 steps
    function automatic step_e step_next(input step_e step, input logic long_code);
        step_e nxt;
        case (step)
            STEP_SQ_1: nxt = STEP_P3_1;
            STEP_P3_1: nxt = long_code ? STEP_P5_1 : STEP_SQ_2;
            STEP_P5_1: nxt = STEP_P7_1;
            STEP_P7_1: nxt = STEP_SQ_2;
            STEP_SQ_2: nxt = STEP_P3_2;
            STEP_P3_2: nxt = STEP_P5_2;
            STEP_P5_2: nxt = STEP_P7_2;
            default:   nxt = STEP_SQ_1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/flip_alpha_gen_if.sv
// Frame input and flip-operand result bundle between LLR buffer, alpha generator and flip-syndrome stage.
interface flip_alpha_gen_if #(
    parameter int unsigned MAG_W = 7,
    parameter int unsigned GF_W  = 10
);

    logic             i_mode;
    logic [1:0]       i_code;
    logic             i_start;
    logic             i_llr_valid;
    logic [MAG_W-1:0] i_llr_mag;

    logic [GF_W-1:0]  o_pos_1;
    logic [GF_W-1:0]  o_pos_2;
    logic [GF_W-1:0]  o_flip_alpha_S1_1;
    logic [GF_W-1:0]  o_flip_alpha_S3_1;
    logic [GF_W-1:0]  o_flip_alpha_S5_1;
    logic [GF_W-1:0]  o_flip_alpha_S7_1;
    logic [GF_W-1:0]  o_flip_alpha_S1_2;
    logic [GF_W-1:0]  o_flip_alpha_S3_2;
    logic [GF_W-1:0]  o_flip_alpha_S5_2;
    logic [GF_W-1:0]  o_flip_alpha_S7_2;
    logic             o_flip_alpha_valid;
    logic             o_busy;

    // Upstream/consumer side
    modport master (
        output i_mode, i_code, i_start, i_llr_valid, i_llr_mag,
        input  o_pos_1, o_pos_2,
        input  o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
        input  o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
        input  o_flip_alpha_valid, o_busy
    );

    // Alpha generator side
    modport slave (
        input  i_mode, i_code, i_start, i_llr_valid, i_llr_mag,
        output o_pos_1, o_pos_2,
        output o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
        output o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
        output o_flip_alpha_valid, o_busy
    );

endinterface

// File: rtl/flip_alpha_gen_gf_mult.sv
// Combinational GF(2^m) multiplier for the three supported fields, MSB-first shift-and-add.
module gf_mult
    import flip_alpha_gen_pkg::*;
#(
    parameter int unsigned GF_W = 10
) (
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    input  logic [1:0]      i_code,
    output logic [GF_W-1:0] o_product
);

    logic [GF_W-1:0] acc;

    // Horner evaluation over the bits of i_b, reducing after every shift
    always_comb begin
        acc = '0;
        for (int i = int'(GF_W) - 1; i >= 0; i--) begin
            acc = GF_W'(gf_xtime(FIELD_W'(acc), i_code));
            if (i_b[i]) begin
                acc = acc ^ i_a;
            end
        end
        o_product = acc;
    end

endmodule

// File: rtl/flip_alpha_gen.sv
// Chase flip front end: finds the two least-reliable positions in a frame and
// produces alpha^(k*pos) for k = 1, 3, 5, 7 for the flip-syndrome stage.
module flip_alpha_gen
    import flip_alpha_gen_pkg::*;
#(
    parameter int unsigned MAG_W = 7,
    parameter int unsigned GF_W  = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    flip_alpha_gen_if.slave fa
);

    // Above any legal magnitude so the first two samples always displace it
    localparam logic [MAG_W:0] MAG_SENTINEL = {1'b1, {MAG_W{1'b0}}};

    state_e          state;
    state_e          state_nxt;
    step_e           step;
    step_e           step_nxt;

    logic            start_acc_c;
    logic            scan_init_c;
    logic            sample_c;
    logic            calc_c;
    logic            long_code_c;
    logic            last_idx_c;
    logic            last_step_c;

    logic [1:0]      code_q;
    logic [GF_W-1:0] idx;
    logic [GF_W-1:0] alpha;
    logic [MAG_W:0]  min1;
    logic [MAG_W:0]  min2;
    logic [MAG_W:0]  mag_ext_c;
    logic [GF_W-1:0] pos1;
    logic [GF_W-1:0] pos2;
    logic [GF_W-1:0] a1;
    logic [GF_W-1:0] a2;
    logic [GF_W-1:0] sq;

    logic [GF_W-1:0] mul_a_c;
    logic [GF_W-1:0] mul_b_c;
    logic [GF_W-1:0] mul_p_c;

    assign start_acc_c = fa.i_start & fa.i_mode;
    assign long_code_c = code_is_long(code_q);
    assign last_idx_c  = (idx == GF_W'(code_nlast(code_q)));
    assign last_step_c = long_code_c ? (step == STEP_P7_2) : (step == STEP_P3_2);
    assign mag_ext_c   = {1'b0, fa.i_llr_mag};

    // State and CALC step registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            step  <= STEP_SQ_1;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state logic and per-cycle datapath enables
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        scan_init_c = 1'b0;
        sample_c    = 1'b0;
        calc_c      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_acc_c) begin
                    state_nxt   = ST_SCAN;
                    scan_init_c = 1'b1;
                end
            end
            ST_SCAN: begin
                if (start_acc_c) begin
                    scan_init_c = 1'b1;
                end else if (fa.i_llr_valid) begin
                    sample_c = 1'b1;
                    if (last_idx_c) begin
                        state_nxt = ST_CALC;
                        step_nxt  = STEP_SQ_1;
                    end
                end
            end
            ST_CALC: begin
                if (start_acc_c) begin
                    state_nxt   = ST_SCAN;
                    scan_init_c = 1'b1;
                end else begin
                    calc_c = 1'b1;
                    if (last_step_c) begin
                        state_nxt = ST_DONE;
                    end else begin
                        step_nxt = step_next(step, long_code_c);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scan datapath: running index, alpha^index and the two smallest magnitudes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_q <= '0;
            idx    <= '0;
            alpha  <= '0;
            min1   <= '0;
            min2   <= '0;
            pos1   <= '0;
            pos2   <= '0;
            a1     <= '0;
            a2     <= '0;
        end else if (scan_init_c) begin
            code_q <= fa.i_code;
            idx    <= '0;
            alpha  <= GF_W'(1);
            min1   <= MAG_SENTINEL;
            min2   <= MAG_SENTINEL;
            pos1   <= '0;
            pos2   <= '0;
            a1     <= '0;
            a2     <= '0;
        end else if (sample_c) begin
            if (mag_ext_c < min1) begin
                min2 <= min1;
                pos2 <= pos1;
                a2   <= a1;
                min1 <= mag_ext_c;
                pos1 <= idx;
                a1   <= alpha;
            end else if (mag_ext_c < min2) begin
                min2 <= mag_ext_c;
                pos2 <= idx;
                a2   <= alpha;
            end
            idx   <= idx + GF_W'(1);
            alpha <= GF_W'(gf_xtime(FIELD_W'(alpha), code_q));
        end
    end

    // Operand select for the shared multiplier; odd powers reuse the previous power times the square
    always_comb begin
        mul_a_c = a1;
        mul_b_c = a1;
        case (step)
            STEP_SQ_1: begin mul_a_c = a1;                   mul_b_c = a1; end
            STEP_P3_1: begin mul_a_c = sq;                   mul_b_c = a1; end
            STEP_P5_1: begin mul_a_c = fa.o_flip_alpha_S3_1; mul_b_c = sq; end
            STEP_P7_1: begin mul_a_c = fa.o_flip_alpha_S5_1; mul_b_c = sq; end
            STEP_SQ_2: begin mul_a_c = a2;                   mul_b_c = a2; end
            STEP_P3_2: begin mul_a_c = sq;                   mul_b_c = a2; end
            STEP_P5_2: begin mul_a_c = fa.o_flip_alpha_S3_2; mul_b_c = sq; end
            STEP_P7_2: begin mul_a_c = fa.o_flip_alpha_S5_2; mul_b_c = sq; end
            default:   begin mul_a_c = a1;                   mul_b_c = a1; end
        endcase
    end

    gf_mult #(
        .GF_W (GF_W)
    ) u_gf_mult (
        .i_a       (mul_a_c),
        .i_b       (mul_b_c),
        .i_code    (code_q),
        .o_product (mul_p_c)
    );

    // Result registers: filled step by step during CALC, held through DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sq                    <= '0;
            fa.o_pos_1            <= '0;
            fa.o_pos_2            <= '0;
            fa.o_flip_alpha_S1_1  <= '0;
            fa.o_flip_alpha_S3_1  <= '0;
            fa.o_flip_alpha_S5_1  <= '0;
            fa.o_flip_alpha_S7_1  <= '0;
            fa.o_flip_alpha_S1_2  <= '0;
            fa.o_flip_alpha_S3_2  <= '0;
            fa.o_flip_alpha_S5_2  <= '0;
            fa.o_flip_alpha_S7_2  <= '0;
            fa.o_flip_alpha_valid <= 1'b0;
            fa.o_busy             <= 1'b0;
        end else begin
            fa.o_busy             <= (state_nxt == ST_SCAN) || (state_nxt == ST_CALC);
            fa.o_flip_alpha_valid <= (state_nxt == ST_DONE);
            if (calc_c) begin
                case (step)
                    STEP_SQ_1: begin
                        sq                   <= mul_p_c;
                        fa.o_pos_1           <= pos1;
                        fa.o_pos_2           <= pos2;
                        fa.o_flip_alpha_S1_1 <= a1;
                        fa.o_flip_alpha_S1_2 <= a2;
                        fa.o_flip_alpha_S5_1 <= '0;
                        fa.o_flip_alpha_S7_1 <= '0;
                        fa.o_flip_alpha_S5_2 <= '0;
                        fa.o_flip_alpha_S7_2 <= '0;
                    end
                    STEP_P3_1: fa.o_flip_alpha_S3_1 <= mul_p_c;
                    STEP_P5_1: fa.o_flip_alpha_S5_1 <= mul_p_c;
                    STEP_P7_1: fa.o_flip_alpha_S7_1 <= mul_p_c;
                    STEP_SQ_2: sq                   <= mul_p_c;
                    STEP_P3_2: fa.o_flip_alpha_S3_2 <= mul_p_c;
                    STEP_P5_2: fa.o_flip_alpha_S5_2 <= mul_p_c;
                    STEP_P7_2: fa.o_flip_alpha_S7_2 <= mul_p_c;
                    default:   sq                   <= sq;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Scoreboard bench for flip_alpha_gen: frames push expected results, a monitor checks each valid rise.
module tb_flip_alpha_gen;

    localparam int unsigned MAG_W = 7;
    localparam int unsigned GF_W  = 10;

    typedef struct {
        logic [GF_W-1:0] pos1;
        logic [GF_W-1:0] pos2;
        logic [GF_W-1:0] s1_1;
        logic [GF_W-1:0] s3_1;
        logic [GF_W-1:0] s5_1;
        logic [GF_W-1:0] s7_1;
        logic [GF_W-1:0] s1_2;
        logic [GF_W-1:0] s3_2;
        logic [GF_W-1:0] s5_2;
        logic [GF_W-1:0] s7_2;
        int              lat;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;
    int   cyc    = 0;
    int   last_t = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;
    exp_t sb_q[$];

    flip_alpha_gen_if #(.MAG_W(MAG_W), .GF_W(GF_W)) fa ();

    flip_alpha_gen #(
        .MAG_W (MAG_W),
        .GF_W  (GF_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .fa    (fa)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Monitor: every rising edge of valid consumes one expected result
    always @(negedge i_clk) begin
        exp_t e;
        if (fa.o_flip_alpha_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: valid rose with no frame outstanding (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("pos_1",   32'(fa.o_pos_1),           32'(e.pos1));
                chk("pos_2",   32'(fa.o_pos_2),           32'(e.pos2));
                chk("S1_1",    32'(fa.o_flip_alpha_S1_1), 32'(e.s1_1));
                chk("S3_1",    32'(fa.o_flip_alpha_S3_1), 32'(e.s3_1));
                chk("S5_1",    32'(fa.o_flip_alpha_S5_1), 32'(e.s5_1));
                chk("S7_1",    32'(fa.o_flip_alpha_S7_1), 32'(e.s7_1));
                chk("S1_2",    32'(fa.o_flip_alpha_S1_2), 32'(e.s1_2));
                chk("S3_2",    32'(fa.o_flip_alpha_S3_2), 32'(e.s3_2));
                chk("S5_2",    32'(fa.o_flip_alpha_S5_2), 32'(e.s5_2));
                chk("S7_2",    32'(fa.o_flip_alpha_S7_2), 32'(e.s7_2));
                chk("latency", 32'(cyc - last_t),         32'(e.lat));
                chk("busy_at_valid", 32'(fa.o_busy),      32'(0));
            end
        end
        prev_v = fa.o_flip_alpha_valid;
    end

    task automatic push_exp(input int p1, input int p2,
                            input int s11, input int s31, input int s51, input int s71,
                            input int s12, input int s32, input int s52, input int s72,
                            input int lat);
        exp_t e;
        e.pos1 = GF_W'(p1);  e.pos2 = GF_W'(p2);
        e.s1_1 = GF_W'(s11); e.s3_1 = GF_W'(s31); e.s5_1 = GF_W'(s51); e.s7_1 = GF_W'(s71);
        e.s1_2 = GF_W'(s12); e.s3_2 = GF_W'(s32); e.s5_2 = GF_W'(s52); e.s7_2 = GF_W'(s72);
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    // Start pulse followed by nsamp samples; base magnitude except at p1/p2
    task automatic feed(input logic [1:0] code, input logic mode,
                        input int p1, input int m1, input int p2, input int m2,
                        input int base, input int nsamp, input bit gaps);
        @(posedge i_clk); #1;
        fa.i_code      = code;
        fa.i_mode      = mode;
        fa.i_start     = 1'b1;
        fa.i_llr_valid = 1'b0;
        @(posedge i_clk); #1;
        fa.i_start = 1'b0;
        fa.i_code  = ~code;
        @(negedge i_clk);
        chk("busy_after_start",  32'(fa.o_busy),             32'(mode));
        chk("valid_after_start", 32'(fa.o_flip_alpha_valid), 32'(0));
        for (int i = 0; i < nsamp; i++) begin
            if (gaps && (i % 17) == 5) begin
                fa.i_llr_valid = 1'b0;
                @(posedge i_clk); #1;
            end
            fa.i_llr_valid = 1'b1;
            fa.i_llr_mag   = MAG_W'((i == p1) ? m1 : (i == p2) ? m2 : base);
            last_t         = cyc;
            @(posedge i_clk); #1;
        end
        fa.i_llr_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) @(negedge i_clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb_q.size(), limit);
            sb_q.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst          = 1'b1;
        fa.i_mode      = 1'b0;
        fa.i_code      = 2'b00;
        fa.i_start     = 1'b0;
        fa.i_llr_valid = 1'b0;
        fa.i_llr_mag   = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_busy",  32'(fa.o_busy),             32'(0));
        chk("rst_valid", 32'(fa.o_flip_alpha_valid), 32'(0));
        chk("rst_pos_1", 32'(fa.o_pos_1),            32'(0));
        chk("rst_S1_1",  32'(fa.o_flip_alpha_S1_1),  32'(0));
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Soft mode off: start and samples are ignored
        feed(2'b00, 1'b0, 5, 3, 40, 7, 100, 63, 1'b0);
        repeat (10) @(negedge i_clk);
        chk("mode0_busy",  32'(fa.o_busy),             32'(0));
        chk("mode0_valid", 32'(fa.o_flip_alpha_valid), 32'(0));
        chk("mode0_pos_1", 32'(fa.o_pos_1),            32'(0));
        chk("mode0_S1_1",  32'(fa.o_flip_alpha_S1_1),  32'(0));

        // GF(2^6): pos 5 -> alpha^5 = 0x20, alpha^15 = 0x28; pos 40 -> 0x2F, alpha^120 = alpha^57 = 0x3E
        push_exp(5, 40, 'h20, 'h28, 0, 0, 'h2F, 'h3E, 0, 0, 5);
        feed(2'b00, 1'b1, 5, 3, 40, 7, 100, 63, 1'b1);
        drain(40);

        // GF(2^8) all ties: earliest two positions win
        push_exp(0, 1, 'h001, 'h001, 0, 0, 'h002, 'h008, 0, 0, 5);
        feed(2'b01, 1'b1, -1, 0, -1, 0, 10, 255, 1'b0);
        drain(40);

        // GF(2^10): alpha^1,3,5,7 and alpha^2,6,10,14 (alpha^10 = x^3+1, alpha^14 = x^7+x^4)
        push_exp(1, 2, 'h002, 'h008, 'h020, 'h080, 'h004, 'h040, 'h009, 'h090, 9);
        feed(2'b10, 1'b1, 1, 0, 2, 0, 50, 1023, 1'b0);
        drain(40);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(fa.o_flip_alpha_valid), 32'(1));
            chk("hold_S5_1",  32'(fa.o_flip_alpha_S5_1),  32'('h020));
            chk("hold_S7_2",  32'(fa.o_flip_alpha_S7_2),  32'('h090));
        end

        // Restart at sample 30: planted minima at 3/10 must be discarded
        // pos 20 -> 0x3C, alpha^60 = 0x39; pos 50 -> 0x34, alpha^150 = alpha^24 = 0x11
        push_exp(20, 50, 'h3C, 'h39, 0, 0, 'h34, 'h11, 0, 0, 5);
        feed(2'b00, 1'b1, 3, 1, 10, 2, 100, 30, 1'b0);
        feed(2'b00, 1'b1, 20, 4, 50, 5, 100, 63, 1'b0);
        drain(40);

        // Reset while in CALC: everything clears on the next cycle, no result emitted
        feed(2'b01, 1'b1, 7, 1, 9, 2, 20, 255, 1'b0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("calc_rst_busy",  32'(fa.o_busy),             32'(0));
        chk("calc_rst_valid", 32'(fa.o_flip_alpha_valid), 32'(0));
        chk("calc_rst_pos_1", 32'(fa.o_pos_1),            32'(0));
        chk("calc_rst_pos_2", 32'(fa.o_pos_2),            32'(0));
        chk("calc_rst_S1_1",  32'(fa.o_flip_alpha_S1_1),  32'(0));
        chk("calc_rst_S3_1",  32'(fa.o_flip_alpha_S3_1),  32'(0));
        chk("calc_rst_S1_2",  32'(fa.o_flip_alpha_S1_2),  32'(0));
        chk("calc_rst_S3_2",  32'(fa.o_flip_alpha_S3_2),  32'(0));
        repeat (12) @(negedge i_clk);

        // Frame after reset, minimum at the last index: alpha^62 = 0x21, alpha^186 = alpha^60 = 0x39
        push_exp(62, 0, 'h21, 'h39, 0, 0, 'h001, 'h001, 0, 0, 5);
        feed(2'b00, 1'b1, 62, 1, 0, 2, 100, 63, 1'b0);
        drain(40);
        chk("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
